window_3x3_gen: RTL and testbench
=================================

# window_3x3_gen

Streaming 3x3 neighbourhood generator. It accepts an 8-bit grayscale pixel stream in raster order and keeps the two previous image lines in line buffers. For every interior pixel it presents the nine pixels of the 3x3 window around that pixel, with a valid strobe. It sits directly upstream of the combinational edge-detection classifier and drives that classifier's nine window inputs.

## Interface

Parameters:

- IMG_WIDTH, 640, pixels per line; minimum 3
- IMG_HEIGHT, 480, lines per frame; minimum 3
- DATA_W, 8, pixel width in bits

Ports:

- clk  input  1  system clock; everything is rising-edge
- rst  input  1  asynchronous, active-high reset
- in_pix  input  DATA_W  incoming pixel
- in_valid  input  1  in_pix is valid this cycle
- in_sof  input  1  start of frame; qualified by in_valid; marks pixel (0,0)
- w0..w8  output  DATA_W each  window, row-major: w0 top-left, w4 centre, w8 bottom-right
- out_valid  output  1  w0..w8, out_x and out_y are valid this cycle
- out_x  output  16  column of the centre pixel w4
- out_y  output  16  row of the centre pixel w4
- frame_done  output  1  one-cycle pulse after the last window of a frame

## Operation

- Column counter col runs 0..IMG_WIDTH-1 and row counter row runs 0..IMG_HEIGHT-1. Both advance only on cycles with in_valid=1.
  - col wraps to 0 at IMG_WIDTH-1 and increments row.
  - row wraps to 0 after the last pixel of the frame.
- in_sof with in_valid forces the current pixel to be (0,0), whatever the counter state. Any partial frame is abandoned; no frame_done is issued for it.
- Two line buffers, each IMG_WIDTH x DATA_W:
  - LB1 holds line row-1.
  - LB2 holds line row-2.
  - On each accepted pixel at column col, LB2[col] takes LB1[col] and LB1[col] takes in_pix. Read and write of the same address must happen in the same cycle.
- Three 3-deep column shift registers (top, middle, bottom) take LB2[col], LB1[col] and in_pix on each accepted pixel.
- A window is emitted when the accepted pixel (col,row) has col>=2 and row>=2. The window is then:
  - w0..w2 = pixels (col-2..col, row-2)
  - w3..w5 = pixels (col-2..col, row-1)
  - w6..w8 = pixels (col-2..col, row)
  - out_x = col-1, out_y = row-1
- There are no windows for border centres (column 0, column IMG_WIDTH-1, row 0, row IMG_HEIGHT-1). Each frame yields exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
- The block never applies backpressure. in_valid may drop at any time; all state holds while in_valid=0.
- State machine (frame phase):
  - IDLE: after reset; waiting for in_sof. Pixels without a preceding in_sof are dropped.
  - FILL: row<2; line buffers loading; no output.
  - STREAM: row>=2; windows emitted.
  - IDLE → FILL on in_sof.
  - FILL → STREAM when row reaches 2.
  - STREAM → IDLE on the last pixel of the frame. frame_done pulses on the following cycle.
  - in_sof in any state → FILL, with the counters reset as above.
- Counter widths: out_x and out_y are zero-extended to 16 bits. No arithmetic on pixel data.

## Timing

- Latency: window outputs are registered. out_valid rises exactly one clk after the rising edge that accepts the completing pixel.
- out_valid is high for one cycle per accepted window-completing pixel. With in_valid continuously high, out_valid is high for IMG_WIDTH-2 consecutive cycles per line, row>=2.
- Outputs hold their last value while out_valid=0.
- frame_done rises one cycle after out_valid for the final window (IMG_WIDTH-2, IMG_HEIGHT-2). It may coincide with a new in_sof acceptance.
- Reset values:
  - w0..w8 = 0, out_x = 0, out_y = 0
  - out_valid = 0, frame_done = 0
  - col = 0, row = 0, state = IDLE
  - Line-buffer contents are don't-care.
- Reset asserted mid-frame: outputs go to their reset values immediately (asynchronous). The next frame needs a fresh in_sof.
- in_sof on the same cycle as the final pixel of a frame: the new-frame start takes priority. That pixel is treated as (0,0) and no window or frame_done is produced for it.

## Test plan

- IMG_WIDTH=4, IMG_HEIGHT=4, pixel = 16*y+x, in_valid constant, in_sof on the first pixel. Expect exactly 4 windows.
  - First window: w0..w8 = 00,01,02,10,11,12,20,21,22, out_x=1, out_y=1.
  - Last window: w0=11, w8=33, out_x=2, out_y=2. frame_done one cycle later.
- Same frame with in_valid toggling in a random 50% pattern: identical window sequence and values. out_valid is only ever high one cycle after an accepted pixel.
- Reset asserted after 9 pixels, then a full 4x4 frame: outputs go to 0 immediately; the subsequent frame produces the same 4 windows as the first test.
- in_sof re-asserted at pixel (1,2) of a 5x5 frame, then a full 5x5 frame: no frame_done for the aborted frame; 9 windows, first at (1,1) with the new data only.
- IMG_WIDTH=640, IMG_HEIGHT=480 random image compared against a software 3x3 reference: 638*478 = 304964 windows, all matching; out_x and out_y strictly raster-ordered.
- Pixels streamed before any in_sof after reset: no out_valid and no frame_done until a frame starting with in_sof completes its third line.

Source files
------------

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus three column
// shift registers turn a raster pixel stream into registered 3x3 windows.
module window_3x3_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_pix,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic [DATA_W-1:0] w0,
    output logic [DATA_W-1:0] w1,
    output logic [DATA_W-1:0] w2,
    output logic [DATA_W-1:0] w3,
    output logic [DATA_W-1:0] w4,
    output logic [DATA_W-1:0] w5,
    output logic [DATA_W-1:0] w6,
    output logic [DATA_W-1:0] w7,
    output logic [DATA_W-1:0] w8,
    output logic              out_valid,
    output logic [15:0]       out_x,
    output logic [15:0]       out_y,
    output logic              frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d, cur_col_s;
    logic [RW-1:0]     row_q, row_d, cur_row_s;
    logic              accept_s, last_col_s, last_pix_s, win_s;
    logic              done_pend_q, done_pend_d;
    logic [DATA_W-1:0] lb1_q [IMG_WIDTH];
    logic [DATA_W-1:0] lb2_q [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_rd_s, lb2_rd_s;
    // Index 0 is the previous column, index 1 the one before; the live
    // column comes straight from the line-buffer reads and in_pix.
    logic [DATA_W-1:0] top_q [2];
    logic [DATA_W-1:0] mid_q [2];
    logic [DATA_W-1:0] bot_q [2];
    logic [DATA_W-1:0] w0_q, w1_q, w2_q, w3_q, w4_q, w5_q, w6_q, w7_q, w8_q;
    logic              out_valid_q, frame_done_q;
    logic [15:0]       out_x_q, out_y_q;

    // Pixel position, acceptance, window strobe and frame-phase next state
    always_comb begin
        accept_s    = in_valid && (in_sof || (state_q != IDLE));
        cur_col_s   = in_sof ? '0 : col_q;
        cur_row_s   = in_sof ? '0 : row_q;
        last_col_s  = (cur_col_s == CW'(IMG_WIDTH - 1));
        last_pix_s  = last_col_s && (cur_row_s == RW'(IMG_HEIGHT - 1));
        win_s       = accept_s && !in_sof && (state_q == STREAM) && (col_q >= CW'(2));
        done_pend_d = accept_s && !in_sof && (state_q == STREAM) && last_pix_s;
        lb1_rd_s    = lb1_q[cur_col_s];
        lb2_rd_s    = lb2_q[cur_col_s];
        col_d       = col_q;
        row_d       = row_q;
        state_d     = state_q;
        if (accept_s) begin
            if (last_col_s) begin
                col_d = '0;
                row_d = last_pix_s ? '0 : (cur_row_s + RW'(1));
            end else begin
                col_d = cur_col_s + CW'(1);
                row_d = cur_row_s;
            end
            if (in_sof) begin
                state_d = FILL;
            end else begin
                case (state_q)
                    FILL:    state_d = (last_col_s && (cur_row_s == RW'(1))) ? STREAM : FILL;
                    STREAM:  state_d = last_pix_s ? IDLE : STREAM;
                    default: state_d = IDLE;
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Frame-phase state, counters, column shift registers and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            done_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_x_q      <= 16'd0;
            out_y_q      <= 16'd0;
            top_q        <= '{default: '0};
            mid_q        <= '{default: '0};
            bot_q        <= '{default: '0};
            {w0_q, w1_q, w2_q, w3_q, w4_q, w5_q, w6_q, w7_q, w8_q} <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            done_pend_q  <= done_pend_d;
            frame_done_q <= done_pend_q;
            out_valid_q  <= win_s;
            if (accept_s) begin
                top_q <= '{lb2_rd_s, top_q[0]};
                mid_q <= '{lb1_rd_s, mid_q[0]};
                bot_q <= '{in_pix, bot_q[0]};
            end
            if (win_s) begin
                w0_q    <= top_q[1];
                w1_q    <= top_q[0];
                w2_q    <= lb2_rd_s;
                w3_q    <= mid_q[1];
                w4_q    <= mid_q[0];
                w5_q    <= lb1_rd_s;
                w6_q    <= bot_q[1];
                w7_q    <= bot_q[0];
                w8_q    <= in_pix;
                out_x_q <= 16'(col_q) - 16'd1;
                out_y_q <= 16'(row_q) - 16'd1;
            end
        end
    end

    // Line buffers: read-before-write on the same address in one cycle
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb2_q[cur_col_s] <= lb1_q[cur_col_s];
            lb1_q[cur_col_s] <= in_pix;
        end
    end

    assign w0         = w0_q;
    assign w1         = w1_q;
    assign w2         = w2_q;
    assign w3         = w3_q;
    assign w4         = w4_q;
    assign w5         = w5_q;
    assign w6         = w6_q;
    assign w7         = w7_q;
    assign w8         = w8_q;
    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen: a 4x4 and a 5x5 instance, windows
// captured after each rising edge and checked per scenario.
module tb_window_3x3_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid4 = 1'b0, in_sof4 = 1'b0, in_valid5 = 1'b0, in_sof5 = 1'b0;
    logic [7:0] in_pix4 = 8'd0, in_pix5 = 8'd0;
    logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
    logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8;
    logic       ov4, fd4, ov5, fd5;
    logic [15:0] ox4, oy4, ox5, oy5;

    window_3x3_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_W(8)) dut4 (
        .clk(clk), .rst(rst), .in_pix(in_pix4), .in_valid(in_valid4), .in_sof(in_sof4),
        .w0(a0), .w1(a1), .w2(a2), .w3(a3), .w4(a4), .w5(a5), .w6(a6), .w7(a7), .w8(a8),
        .out_valid(ov4), .out_x(ox4), .out_y(oy4), .frame_done(fd4));

    window_3x3_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(5), .DATA_W(8)) dut5 (
        .clk(clk), .rst(rst), .in_pix(in_pix5), .in_valid(in_valid5), .in_sof(in_sof5),
        .w0(b0), .w1(b1), .w2(b2), .w3(b3), .w4(b4), .w5(b5), .w6(b6), .w7(b7), .w8(b8),
        .out_valid(ov5), .out_x(ox5), .out_y(oy5), .frame_done(fd5));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [71:0] win4_q[$], win5_q[$];
    logic [15:0] x4_q[$], y4_q[$], x5_q[$], y5_q[$];
    int done4_n = 0, done5_n = 0, viol4_n = 0;
    int lastv4 = 0, donec4 = 0, lastv5 = 0, donec5 = 0;
    logic v4_s, v5_s;

    // Capture windows and frame_done pulses shortly after each rising edge
    always @(posedge clk) begin
        v4_s = in_valid4;
        v5_s = in_valid5;
        #1;
        cyc = cyc + 1;
        if (ov4 === 1'b1) begin
            win4_q.push_back({a0, a1, a2, a3, a4, a5, a6, a7, a8});
            x4_q.push_back(ox4);
            y4_q.push_back(oy4);
            lastv4 = cyc;
            if (v4_s !== 1'b1) viol4_n = viol4_n + 1;
        end
        if (fd4 === 1'b1) begin
            done4_n = done4_n + 1;
            donec4 = cyc;
        end
        if (ov5 === 1'b1) begin
            win5_q.push_back({b0, b1, b2, b3, b4, b5, b6, b7, b8});
            x5_q.push_back(ox5);
            y5_q.push_back(oy5);
            lastv5 = cyc;
        end
        if (fd5 === 1'b1) begin
            done5_n = done5_n + 1;
            donec5 = cyc;
        end
    end

    // Expected window for centre (cx,cy) of an image whose pixel is 16*y+x + base
    function automatic logic [71:0] exp_win(input int cx, input int cy, input int base);
        logic [71:0] r;
        r = 72'd0;
        for (int yy = 0; yy < 3; yy++)
            for (int xx = 0; xx < 3; xx++)
                r = (r << 8) | 72'(8'(16 * (cy - 1 + yy) + (cx - 1 + xx) + base));
        return r;
    endfunction

    task automatic clear_caps();
        win4_q.delete(); x4_q.delete(); y4_q.delete();
        win5_q.delete(); x5_q.delete(); y5_q.delete();
        done4_n = 0; done5_n = 0; viol4_n = 0;
    endtask

    task automatic drive4(input logic v, input logic s, input logic [7:0] p);
        @(negedge clk);
        in_valid4 = v; in_sof4 = s; in_pix4 = p;
    endtask

    task automatic drive5(input logic v, input logic s, input logic [7:0] p);
        @(negedge clk);
        in_valid5 = v; in_sof5 = s; in_pix5 = p;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive4(1'b0, 1'b0, 8'hEE);
            drive5(1'b0, 1'b0, 8'hEE);
        end
    endtask

    // Full 4x4 frame with pixel 16*y+x; optional random idle gaps between pixels
    task automatic send_frame4(input bit gaps);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) begin
                if (gaps)
                    for (int k = 0; k < 4 && $urandom_range(0, 1) == 1; k++)
                        drive4(1'b0, 1'b0, 8'hEE);
                drive4(1'b1, (x == 0 && y == 0), 8'(16 * y + x));
            end
        drive4(1'b0, 1'b0, 8'hEE);
    endtask

    task automatic check_std4(input string tag);
        checks++;
        if (win4_q.size() !== 4) begin
            errors++;
            $display("FAIL %s count: got %0d want 4", tag, win4_q.size());
        end
        for (int i = 0; i < 4 && i < win4_q.size(); i++) begin
            checks++;
            if (win4_q[i] !== exp_win(1 + i % 2, 1 + i / 2, 0) ||
                x4_q[i] !== 16'(1 + i % 2) || y4_q[i] !== 16'(1 + i / 2)) begin
                errors++;
                $display("FAIL %s win%0d: got %h x=%0d y=%0d want %h x=%0d y=%0d", tag, i,
                         win4_q[i], x4_q[i], y4_q[i], exp_win(1 + i % 2, 1 + i / 2, 0),
                         1 + i % 2, 1 + i / 2);
            end
        end
        checks++;
        if (done4_n !== 1 || donec4 !== lastv4 + 1) begin
            errors++;
            $display("FAIL %s frame_done: got n=%0d cyc=%0d want n=1 cyc=%0d", tag, done4_n,
                     donec4, lastv4 + 1);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({a0, a4, a8, b0, b8} !== 40'd0 || ov4 !== 1'b0 || fd4 !== 1'b0 ||
            ox4 !== 16'd0 || oy4 !== 16'd0 || ov5 !== 1'b0 || fd5 !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got w0=%h w8=%h ov=%b fd=%b x=%0d y=%0d want all 0",
                     a0, a8, ov4, fd4, ox4, oy4);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_frame();
        clear_caps();
        send_frame4(1'b0);
        idle(3);
        checks++;
        if (win4_q.size() > 0 && win4_q[0] !== 72'h00_01_02_10_11_12_20_21_22) begin
            errors++;
            $display("FAIL first_window: got %h want 000102101112202122", win4_q[0]);
        end
        checks++;
        if (win4_q.size() == 4 && (win4_q[3][71:64] !== 8'h11 || win4_q[3][7:0] !== 8'h33)) begin
            errors++;
            $display("FAIL last_window: got w0=%h w8=%h want w0=11 w8=33",
                     win4_q[3][71:64], win4_q[3][7:0]);
        end
        check_std4("frame");
    endtask

    task automatic test_gaps();
        clear_caps();
        send_frame4(1'b1);
        idle(3);
        check_std4("gaps");
        checks++;
        if (viol4_n !== 0) begin
            errors++;
            $display("FAIL gaps_valid_timing: got %0d stray out_valid want 0", viol4_n);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) drive4(1'b1, (i == 0), 8'(16 * (i / 4) + i % 4));
        @(negedge clk);
        in_valid4 = 1'b0; in_sof4 = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({a0, a4, a8} !== 24'd0 || ox4 !== 16'd0 || oy4 !== 16'd0 || ov4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got w0=%h w4=%h x=%0d y=%0d want 0", a0, a4, ox4, oy4);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_caps();
        send_frame4(1'b0);
        idle(3);
        check_std4("after_reset");
    endtask

    task automatic test_no_sof();
        clear_caps();
        for (int i = 0; i < 20; i++) drive4(1'b1, 1'b0, 8'(i + 100));
        idle(3);
        checks++;
        if (win4_q.size() !== 0 || done4_n !== 0) begin
            errors++;
            $display("FAIL no_sof: got windows=%0d done=%0d want 0 0", win4_q.size(), done4_n);
        end
        send_frame4(1'b0);
        idle(3);
        check_std4("no_sof_then_frame");
    endtask

    task automatic test_back_to_back();
        clear_caps();
        for (int i = 0; i < 15; i++) drive4(1'b1, (i == 0), 8'(16 * (i / 4) + i % 4));
        for (int i = 0; i < 16; i++) drive4(1'b1, (i == 0), 8'(16 * (i / 4) + i % 4));
        idle(3);
        checks++;
        if (win4_q.size() !== 7 || done4_n !== 1 || donec4 !== lastv4 + 1) begin
            errors++;
            $display("FAIL sof_on_last: got windows=%0d done=%0d want 7 1", win4_q.size(), done4_n);
        end
        for (int i = 0; i < 7 && i < win4_q.size(); i++) begin
            int j;
            j = (i < 3) ? i : i - 3;
            checks++;
            if (win4_q[i] !== exp_win(1 + j % 2, 1 + j / 2, 0)) begin
                errors++;
                $display("FAIL sof_on_last win%0d: got %h want %h", i, win4_q[i],
                         exp_win(1 + j % 2, 1 + j / 2, 0));
            end
        end
    endtask

    task automatic test_abort();
        clear_caps();
        for (int i = 0; i < 11; i++) drive5(1'b1, (i == 0), 8'(8'hFF - (16 * (i / 5) + i % 5)));
        for (int i = 0; i < 25; i++) drive5(1'b1, (i == 0), 8'(16 * (i / 5) + i % 5));
        idle(3);
        checks++;
        if (win5_q.size() !== 9 || done5_n !== 1 || donec5 !== lastv5 + 1) begin
            errors++;
            $display("FAIL abort: got windows=%0d done=%0d want 9 1", win5_q.size(), done5_n);
        end
        for (int i = 0; i < 9 && i < win5_q.size(); i++) begin
            checks++;
            if (win5_q[i] !== exp_win(1 + i % 3, 1 + i / 3, 0) ||
                x5_q[i] !== 16'(1 + i % 3) || y5_q[i] !== 16'(1 + i / 3)) begin
                errors++;
                $display("FAIL abort win%0d: got %h x=%0d y=%0d want %h x=%0d y=%0d", i,
                         win5_q[i], x5_q[i], y5_q[i], exp_win(1 + i % 3, 1 + i / 3, 0),
                         1 + i % 3, 1 + i / 3);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_frame();
        test_gaps();
        test_reset_mid();
        test_no_sof();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
